sd_image_server: RTL

SD_IMAGE_SERVER -- requirements
Module: sd_image_server

---
 rtl/sd_image_server.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/sd_image_server.sv
// sd_image_server: serves 512-byte sectors between a byte-wide image
// memory and a client track loader using a level-request handshake.
// Ports:
//   clk_sys, reset        clock, async active-high reset
//   sd_lba/sd_rd/sd_wr    client request (sector, read, write)
//   sd_ack                high for the whole transfer
//   sd_buff_addr/_dout/_wr/_din  client sector buffer port
//   img_addr/_rd/_wr/_wdata/_rdata  image memory port (1-cycle read)
//   err                   pulse on acceptance of an out-of-range sector
// Build option: SD_SERVER_BYTE_GAP_EN inserts one idle cycle per byte.
module sd_image_server #(
  parameter int IMG_AW    = 18,
  parameter int ACK_DELAY = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [31:0]       sd_lba,
  input  logic              sd_rd,
  input  logic              sd_wr,
  output logic              sd_ack,
  output logic [8:0]        sd_buff_addr,
  output logic [7:0]        sd_buff_dout,
  output logic              sd_buff_wr,
  input  logic [7:0]        sd_buff_din,
  output logic [IMG_AW-1:0] img_addr,
  output logic              img_rd,
  output logic              img_wr,
  output logic [7:0]        img_wdata,
  input  logic [7:0]        img_rdata,
  output logic              err
);

  localparam int SW = IMG_AW - 9;

  typedef enum logic [2:0] {
    IDLE,
    DELAY,
    RD_XFER,
    WR_XFER,
    DONE
  } state_t;

  state_t        state;
  logic [7:0]    dly;
  logic [SW-1:0] lba_q;
  logic          oor;
  logic          dir_rd;
  logic [8:0]    byte_cnt;
  logic          issue;
  logic          beat;
  logic          beat_last;
  logic          dout_en;
  logic          adv;
  logic          lba_oor;

  assign lba_oor = (sd_lba >> SW) != 32'd0;

  // issue: byte_cnt is being presented this cycle (img_rd for reads,
  // sd_buff_addr for writes); the matching data beat follows next cycle.
`ifdef SD_SERVER_BYTE_GAP_EN
  assign adv = !issue && (byte_cnt != 9'd511);
`else
  assign adv = issue && (byte_cnt != 9'd511);
`endif

  // Data paths follow the registered strobes so they stay in step with
  // the one-cycle memory read and the one-cycle-late client data.
  assign sd_buff_dout = dout_en ? img_rdata : 8'h00;
  assign img_wdata    = img_wr ? sd_buff_din : 8'h00;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      dly          <= 8'd0;
      lba_q        <= '0;
      oor          <= 1'b0;
      dir_rd       <= 1'b0;
      byte_cnt     <= 9'd0;
      issue        <= 1'b0;
      beat         <= 1'b0;
      beat_last    <= 1'b0;
      dout_en      <= 1'b0;
      sd_ack       <= 1'b0;
      sd_buff_addr <= 9'd0;
      sd_buff_wr   <= 1'b0;
      img_addr     <= '0;
      img_rd       <= 1'b0;
      img_wr       <= 1'b0;
      err          <= 1'b0;
    end else begin
      err        <= 1'b0;
      sd_buff_wr <= 1'b0;
      img_rd     <= 1'b0;
      img_wr     <= 1'b0;
      dout_en    <= 1'b0;
      beat       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sd_rd || sd_wr) begin
            lba_q  <= sd_lba[SW-1:0];
            oor    <= lba_oor;
            err    <= lba_oor;
            dir_rd <= sd_rd;
            dly    <= 8'(ACK_DELAY - 1);
            state  <= DELAY;
          end
        end
        DELAY: begin
          if (dly == 8'd0) begin
            sd_ack    <= 1'b1;
            byte_cnt  <= 9'd0;
            issue     <= 1'b1;
            beat_last <= 1'b0;
            if (dir_rd) begin
              state    <= RD_XFER;
              img_rd   <= !oor;
              img_addr <= {lba_q, 9'd0};
            end else begin
              state        <= WR_XFER;
              sd_buff_addr <= 9'd0;
            end
          end else begin
            dly <= dly - 8'd1;
          end
        end
        RD_XFER: begin
          beat       <= issue;
          beat_last  <= issue && (byte_cnt == 9'd511);
          sd_buff_wr <= issue;
          dout_en    <= img_rd;
          if (issue) begin
            sd_buff_addr <= byte_cnt;
          end
          issue <= adv;
          if (adv) begin
            byte_cnt <= byte_cnt + 9'd1;
            img_rd   <= !oor;
            img_addr <= {lba_q, byte_cnt + 9'd1};
          end
          if (beat && beat_last) begin
            sd_ack <= 1'b0;
            state  <= DONE;
          end
        end
        WR_XFER: begin
          beat      <= issue;
          beat_last <= issue && (byte_cnt == 9'd511);
          img_wr    <= issue && !oor;
          if (issue) begin
            img_addr <= {lba_q, byte_cnt};
          end
          issue <= adv;
          if (adv) begin
            byte_cnt     <= byte_cnt + 9'd1;
            sd_buff_addr <= byte_cnt + 9'd1;
          end
          if (beat && beat_last) begin
            sd_ack <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          // a request still held from the last transfer must drop first
          if (!sd_rd && !sd_wr) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
